// File: rtl/mcu_pkg.sv
// mcu_pkg: shared MCU widths, boot frame constants and loader state encoding.
package mcu_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [DATA_W-1:0] MAGIC = 16'hB007;
   typedef enum logic [2:0] {LD_IDLE, LD_LEN, LD_DATA, LD_CHK, LD_DONE, LD_ERR} ld_state_e;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: boot-time program memory writer; takes a MAGIC/LEN/payload/CSUM
// stream, writes the payload through a 1-deep write register and releases the CPU once verified.
module prog_loader
   import mcu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [DATA_W-1:0] rom_data_out,
   output logic              rom_cs,
   output logic              rom_we,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);
   ld_state_e         state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d, idx_q, idx_d, idx_inc;
   logic [DATA_W-1:0] csum_q, csum_d, wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_q, wr_d, xfer;
   assign in_ready = rst && !reload && (state_q inside {LD_IDLE, LD_LEN, LD_DATA, LD_CHK});
   assign xfer     = in_valid && in_ready;
   assign idx_inc  = idx_q + (ADDR_W+1)'(1);
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      csum_d  = csum_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = 1'b0;
      if (reload)
         state_d = LD_IDLE;
      else if (xfer)
         case (state_q)
            LD_IDLE: state_d = (in_data == MAGIC) ? LD_LEN : LD_IDLE;
            LD_LEN: begin
               len_d   = in_data[ADDR_W:0];
               idx_d   = '0;
               csum_d  = '0;
               state_d = (in_data == '0 || in_data > DATA_W'(DEPTH)) ? LD_ERR : LD_DATA;
            end
            LD_DATA: begin
               wr_d    = 1'b1;
               addr_d  = idx_q[ADDR_W-1:0];
               wdata_d = in_data;
               csum_d  = csum_q + in_data;
               idx_d   = idx_inc;
               state_d = (idx_inc == len_q) ? LD_CHK : LD_DATA;
            end
            LD_CHK:  state_d = (in_data == csum_q) ? LD_DONE : LD_ERR;
            default: state_d = state_q;
         endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= LD_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         csum_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         csum_q  <= csum_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
      end
   end
   assign rom_cs       = wr_q;
   assign rom_we       = wr_q;
   assign rom_addr     = addr_q;
   assign rom_data_out = wdata_q;
   assign cpu_hold     = state_q != LD_DONE;
   assign load_done    = state_q == LD_DONE;
   assign load_err     = state_q == LD_ERR;
endmodule
